div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1: quotient bits resolved per iteration cycle; legal values are 1 and 2.
REQ-002 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a divide; sampled only in IDLE.
REQ-005 SHALL have port is_signed, input, 1: 1 selects DIV semantics, 0 selects DIVU; sampled with start.
REQ-006 SHALL have port abort, input, 1: cancel the operation in flight, driven from pipeline flush.
REQ-007 SHALL have port dividend, input, 32: operand A; sampled with start.
REQ-008 SHALL have port divisor, input, 32: operand B; sampled with start.
REQ-009 SHALL have port busy, output, 1: high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when quotient and remainder are valid.
REQ-011 SHALL have port quotient, output, 32: registered quotient, written to LO by the consumer.
REQ-012 SHALL have port remainder, output, 32: registered remainder, written to HI by the consumer.
REQ-013 SHALL have port div_by_zero, output, 1: registered flag, updated together with done.

Function
REQ-014 SHALL implement states IDLE, ITER and FIX: IDLE->ITER on accepted start; ITER->FIX when the iteration count reaches 0; FIX->IDLE unconditionally.
REQ-015 SHALL, on accepting start, latch the operand magnitudes (two's-complement absolute value when is_signed=1), both sign bits, is_signed, and an iteration count N=32/BITS_PER_CYCLE.
REQ-016 SHALL, in each ITER cycle, perform BITS_PER_CYCLE restoring-division steps on the 32-bit magnitudes and decrement the count by 1.
REQ-017 SHALL, in FIX, register results: quotient is negated if the sign bits differ; remainder takes the sign of the dividend; both apply only when is_signed=1.
REQ-018 SHALL assert done for exactly one cycle, rising at edge N+2 counted from the edge that sampled start (edge 34 for BITS_PER_CYCLE=1, edge 18 for BITS_PER_CYCLE=2).
REQ-019 SHALL hold quotient, remainder and div_by_zero stable between done pulses.
REQ-020 SHALL ignore start while busy=1; no queueing is performed.
REQ-021 SHALL, on abort while busy, return to IDLE at the next edge with no done pulse and with the outputs unchanged.
REQ-022 SHALL give abort priority over start when both are high in IDLE; the start is dropped.
REQ-023 SHALL, when divisor==0, produce quotient=32'hFFFFFFFF, remainder=raw dividend and div_by_zero=1, regardless of is_signed.
REQ-024 SHALL produce quotient=32'h80000000 and remainder=0 for signed 32'h80000000 / 32'hFFFFFFFF, with no flag.
REQ-025 SHALL accept a new start in the cycle after done (the state is IDLE in that cycle).

Reset
REQ-026 SHALL, on reset_n low, immediately force state=IDLE, count=0, busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0, including when an operation is mid-flight.
REQ-027 SHALL not accept start in the first edge at which reset_n is already high.

Configuration
REQ-028 SHALL support macro DIV_SEQ_EARLY_EXIT_EN.
- Defined: when divisor==0, or the divisor magnitude exceeds the dividend magnitude, IDLE goes directly to FIX and done rises at edge 2. For the magnitude case, quotient=0 and remainder=dividend.
- Undefined: every operation, including divide-by-zero, takes the full N+2 latency.

Structure
REQ-029 SHALL place the state enum type (DIV_IDLE, DIV_ITER, DIV_FIX) and constant DIV_WIDTH=32 in mips_pkg.
REQ-030 SHALL implement one restoring step as combinational sub-module div_step, instantiated BITS_PER_CYCLE times in a chain.

Verification
REQ-031 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, done at edge 34 (BITS_PER_CYCLE=1).
REQ-032 SHALL cover: signed 32'hFFFFFFF9 / 2 -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF.
REQ-033 SHALL cover: signed 32'h80000000 / 32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, div_by_zero=0.
REQ-034 SHALL cover: 5/0 -> quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1; done at edge 2 with the macro defined, at edge 34 without.
REQ-035 SHALL cover: start 100/7, then abort at edge 10 -> busy=0 at edge 11, no done, outputs keep the prior result; a second start at edge 12 completes normally.
REQ-036 SHALL cover: start 9/3, then start 50/5 at edge 5, then reset_n pulsed low at edge 20 -> second start ignored, all outputs 0 immediately on reset, no done.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the sequential divider.
//   DIV_WIDTH   : operand / result width
//   DIV_CNT_W   : width of the iteration counter (must hold DIV_WIDTH)
//   div_state_e : divider FSM states
//   div_mag     : two's-complement magnitude of a value when use_sign=1
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    // Negating 32'h80000000 yields 32'h80000000, which is the correct
    // unsigned magnitude, so no special case is needed.
    function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v,
                                                     input logic                 use_sign);
        return (use_sign && v[DIV_WIDTH-1]) ? (-v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder is shifted left by one, pulling in the next dividend
// bit from the top of quo_i; if the divisor fits it is subtracted and a 1 is
// shifted into the bottom of the quotient/dividend register, else a 0.
// Ports:
//   rem_i     : partial remainder in
//   quo_i     : remaining dividend bits (high) / quotient bits so far (low)
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder out
//   quo_o     : updated dividend/quotient register
// -----------------------------------------------------------------------------
module div_step
    import mips_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic [DIV_WIDTH-1:0] quo_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH-1:0] rem_o,
    output logic [DIV_WIDTH-1:0] quo_o
);

    logic [DIV_WIDTH:0] shifted;
    logic               fits;

    assign shifted = {rem_i, quo_i[DIV_WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor_i});
    // When fits=1 the true difference is below the divisor, so it always
    // fits in DIV_WIDTH bits even if shifted carried into its top bit.
    assign rem_o   = fits ? (shifted[DIV_WIDTH-1:0] - divisor_i) : shifted[DIV_WIDTH-1:0];
    assign quo_o   = {quo_i[DIV_WIDTH-2:0], fits};

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Iterative 32-bit divider supporting DIV (signed) and DIVU (unsigned)
// semantics. Operands are converted to magnitudes, divided with restoring
// steps (BITS_PER_CYCLE per clock, legal values 1 and 2), then sign-fixed.
// Latency: done rises N+2 edges after the start-sampling edge (N=32/BPC).
// Divide by zero yields quotient=all ones, remainder=raw dividend, flag set.
//
// Optional build macro DIV_SEQ_EARLY_EXIT_EN: when defined, a zero divisor or
// a divisor magnitude larger than the dividend magnitude skips the iteration
// phase and done rises 2 edges after the start-sampling edge.
//
// Ports:
//   clock       : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   start       : request a divide (accepted only in IDLE)
//   is_signed   : 1 = DIV, 0 = DIVU (sampled with start)
//   abort       : cancel operation in flight (beats start in IDLE)
//   dividend    : operand A (sampled with start)
//   divisor     : operand B (sampled with start)
//   busy        : high in every non-IDLE state
//   done        : one-cycle pulse when results are valid
//   quotient    : registered quotient
//   remainder   : registered remainder
//   div_by_zero : registered divide-by-zero flag, updated with done
// -----------------------------------------------------------------------------
module div_seq
    import mips_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int                   N_ITER     = DIV_WIDTH / BITS_PER_CYCLE;
    localparam logic [DIV_CNT_W-1:0] N_ITER_CNT = DIV_CNT_W'(N_ITER);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] count_q, count_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DIV_WIDTH-1:0] dvnd_q, dvnd_d;       // raw dividend for the special results
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 signed_q, signed_d;
    logic                 zero_q, zero_d;
    logic                 ready_q, ready_d;     // low on the first edge after reset release
    logic                 done_q, done_d;
    logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic                 dbz_q, dbz_d;
`ifdef DIV_SEQ_EARLY_EXIT_EN
    logic                 early_q, early_d;
`endif

    logic [DIV_WIDTH-1:0] a_mag;
    logic [DIV_WIDTH-1:0] b_mag;

    assign a_mag = div_mag(dividend, is_signed);
    assign b_mag = div_mag(divisor, is_signed);

    // Restoring-step chain: BITS_PER_CYCLE steps evaluated per ITER cycle.
    logic [DIV_WIDTH-1:0] chain_rem [0:BITS_PER_CYCLE];
    logic [DIV_WIDTH-1:0] chain_quo [0:BITS_PER_CYCLE];

    assign chain_rem[0] = rem_q;
    assign chain_quo[0] = quo_q;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            div_step u_step (
                .rem_i     (chain_rem[gi]),
                .quo_i     (chain_quo[gi]),
                .divisor_i (dvsr_q),
                .rem_o     (chain_rem[gi+1]),
                .quo_o     (chain_quo[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dvnd_d      = dvnd_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        signed_d    = signed_q;
        zero_d      = zero_q;
        ready_d     = 1'b1;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SEQ_EARLY_EXIT_EN
        early_d     = early_q;
`endif

        case (state_q)
            DIV_IDLE: begin
                if (!abort && start && ready_q) begin
                    state_d  = DIV_ITER;
                    count_d  = N_ITER_CNT;
                    rem_d    = '0;
                    quo_d    = a_mag;
                    dvsr_d   = b_mag;
                    dvnd_d   = dividend;
                    neg_a_d  = dividend[DIV_WIDTH-1];
                    neg_b_d  = divisor[DIV_WIDTH-1];
                    signed_d = is_signed;
                    zero_d   = (divisor == '0);
`ifdef DIV_SEQ_EARLY_EXIT_EN
                    early_d  = (divisor == '0) || (b_mag > a_mag);
                    if ((divisor == '0) || (b_mag > a_mag)) begin
                        state_d = DIV_FIX;
                        count_d = '0;
                    end
`endif
                end
            end

            DIV_ITER: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d   = chain_rem[BITS_PER_CYCLE];
                    quo_d   = chain_quo[BITS_PER_CYCLE];
                    count_d = count_q - DIV_CNT_W'(1);
                    if (count_q == DIV_CNT_W'(1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end

            DIV_FIX: begin
                state_d = DIV_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    dbz_d  = zero_q;
                    if (zero_q) begin
                        quotient_d  = '1;
                        remainder_d = dvnd_q;
                    end
`ifdef DIV_SEQ_EARLY_EXIT_EN
                    else if (early_q) begin
                        quotient_d  = '0;
                        remainder_d = dvnd_q;
                    end
`endif
                    else begin
                        quotient_d  = (signed_q && (neg_a_q ^ neg_b_q)) ? (-quo_q) : quo_q;
                        remainder_d = (signed_q && neg_a_q) ? (-rem_q) : rem_q;
                    end
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvnd_q      <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            signed_q    <= 1'b0;
            zero_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SEQ_EARLY_EXIT_EN
            early_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dvnd_q      <= dvnd_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            signed_q    <= signed_d;
            zero_q      <= zero_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SEQ_EARLY_EXIT_EN
            early_q     <= early_d;
`endif
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
